// File: rtl/adc_frame_aligner.sv
// ADC frame aligner: bit-slipping gearboxes turn per-lane byte streams into
// DATA_WIDTH-bit samples, aligned against the FCO frame pattern.
module adc_frame_aligner #(
    parameter int NUM_CH       = 4,
    parameter int DATA_WIDTH   = 12,
    parameter int LOCK_COUNT   = 4,
    parameter int LOSS_COUNT   = 3,
    parameter int SETTLE_WORDS = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [7:0]                   fco_byte,
    input  logic [8*NUM_CH-1:0]          din_bytes,
    input  logic                         realign,
    output logic [DATA_WIDTH*NUM_CH-1:0] des_data,
    output logic                         des_data_valid,
    output logic                         locked,
    output logic [7:0]                   slip_count,
    output logic [15:0]                  frame_err_count,
    output logic                         align_fail
);

    localparam int BW = DATA_WIDTH + 8;
    localparam int NG = NUM_CH + 1;

    localparam logic [DATA_WIDTH-1:0] FCO_EXP =
        {{(DATA_WIDTH/2){1'b1}}, {(DATA_WIDTH/2){1'b0}}};

    localparam logic [4:0] W5      = 5'(DATA_WIDTH);
    localparam logic [3:0] LOCK_N  = 4'(LOCK_COUNT);
    localparam logic [3:0] LOSS_N  = 4'(LOSS_COUNT);
    localparam logic [1:0] SETTLE_N = 2'(SETTLE_WORDS);
    localparam logic [7:0] FAIL_AT = 8'(2 * DATA_WIDTH);

    typedef enum logic [1:0] {
        SEARCH,
        SETTLE,
        VERIFY,
        LOCKED
    } state_t;

    state_t state;
    state_t state_n;

    logic [4:0] fill;
    logic [4:0] app_fill;
    logic [4:0] fill_n;
    logic [4:0] shamt;
    logic       emit;
    logic       slip;
    logic       slip_n;
    logic       do_slip;

    logic [7:0]            byte_in [NG];
    logic [BW-1:0]         gb      [NG];
    logic [BW-1:0]         gb_n    [NG];
    logic [DATA_WIDTH-1:0] word    [NG];

    logic [DATA_WIDTH*NUM_CH-1:0] lane_words;
    logic                         fco_ok;
    logic                         valid_n;

    logic [3:0]  match_cnt;
    logic [3:0]  match_n;
    logic [3:0]  miss_cnt;
    logic [3:0]  miss_n;
    logic [1:0]  settle_cnt;
    logic [1:0]  settle_n;
    logic [7:0]  slip_cnt_n;
    logic [15:0] err_n;
    logic        fail_n;

    // Channel 0 is the FCO gearbox; channels 1..NUM_CH are the data lanes.
    assign byte_in[0] = fco_byte;

    for (genvar n = 0; n < NUM_CH; n++) begin : g_lane
        assign byte_in[n+1] = din_bytes[8*n +: 8];
        assign lane_words[DATA_WIDTH*n +: DATA_WIDTH] = word[n+1];
    end

    // A pending slip drops the oldest buffered bit by shrinking the fill.
    always_comb begin
        app_fill = fill + 5'd8 - {4'd0, slip};
        emit     = app_fill >= W5;
        shamt    = emit ? app_fill - W5 : 5'd0;
        fill_n   = emit ? shamt : app_fill;
    end

    always_comb begin
        for (int c = 0; c < NG; c++) begin
            gb_n[c] = {gb[c][BW-9:0], byte_in[c]};
            word[c] = DATA_WIDTH'(gb_n[c] >> shamt);
        end
    end

    assign fco_ok = word[0] == FCO_EXP;
    assign locked = state == LOCKED;

    always_comb begin
        state_n    = state;
        match_n    = match_cnt;
        miss_n     = miss_cnt;
        settle_n   = settle_cnt;
        slip_cnt_n = slip_count;
        err_n      = frame_err_count;
        fail_n     = align_fail;
        do_slip    = 1'b0;
        slip_n     = 1'b0;
        valid_n    = 1'b0;

        if (emit) begin
            unique case (state)
                SEARCH: begin
                    if (fco_ok) begin
                        match_n = 4'd1;
                        miss_n  = 4'd0;
                        state_n = (LOCK_N == 4'd1) ? LOCKED : VERIFY;
                    end else begin
                        do_slip = 1'b1;
                    end
                end
                SETTLE: begin
                    if (settle_cnt + 2'd1 == SETTLE_N) begin
                        settle_n = 2'd0;
                        state_n  = SEARCH;
                    end else begin
                        settle_n = settle_cnt + 2'd1;
                    end
                end
                VERIFY: begin
                    if (fco_ok) begin
                        match_n = match_cnt + 4'd1;
                        if (match_n == LOCK_N) begin
                            state_n = LOCKED;
                            miss_n  = 4'd0;
                        end
                    end else begin
                        do_slip = 1'b1;
                    end
                end
                LOCKED: begin
                    if (fco_ok) begin
                        miss_n = 4'd0;
                    end else begin
                        if (frame_err_count != 16'hFFFF) begin
                            err_n = frame_err_count + 16'd1;
                        end
                        miss_n = miss_cnt + 4'd1;
                        if (miss_n == LOSS_N) begin
                            state_n    = SEARCH;
                            slip_cnt_n = 8'd0;
                            miss_n     = 4'd0;
                            match_n    = 4'd0;
                        end
                    end
                end
            endcase
        end

        // The slip itself is applied on the following edge.
        if (do_slip) begin
            state_n  = SETTLE;
            settle_n = 2'd0;
            match_n  = 4'd0;
            slip_n   = 1'b1;
            if (slip_count != 8'hFF) begin
                slip_cnt_n = slip_count + 8'd1;
            end
            if (slip_cnt_n == FAIL_AT) begin
                fail_n = 1'b1;
            end
        end

        if (realign) begin
            state_n    = SEARCH;
            match_n    = 4'd0;
            miss_n     = 4'd0;
            settle_n   = 2'd0;
            slip_cnt_n = 8'd0;
            err_n      = frame_err_count;
            fail_n     = align_fail;
            slip_n     = 1'b0;
        end

        valid_n = emit && (state == LOCKED) && (state_n == LOCKED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fill <= 5'd0;
            for (int c = 0; c < NG; c++) begin
                gb[c] <= '0;
            end
        end else begin
            fill <= fill_n;
            for (int c = 0; c < NG; c++) begin
                gb[c] <= gb_n[c];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= SEARCH;
            slip            <= 1'b0;
            match_cnt       <= 4'd0;
            miss_cnt        <= 4'd0;
            settle_cnt      <= 2'd0;
            slip_count      <= 8'd0;
            frame_err_count <= 16'd0;
            align_fail      <= 1'b0;
        end else begin
            state           <= state_n;
            slip            <= slip_n;
            match_cnt       <= match_n;
            miss_cnt        <= miss_n;
            settle_cnt      <= settle_n;
            slip_count      <= slip_cnt_n;
            frame_err_count <= err_n;
            align_fail      <= fail_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            des_data       <= '0;
            des_data_valid <= 1'b0;
        end else begin
            des_data_valid <= valid_n;
            if (valid_n) begin
                des_data <= lane_words;
            end
        end
    end

endmodule
